// File: rtl/mem_byte_responder.sv
// Memory-side responder: word read, full write and byte-enabled write (done as read-modify-write)
// in front of a single-port word memory. Define MEM_BYTE_ALIGN_CHECK_EN to reject misaligned word accesses.

module mem_byte_lane (
  input  logic       en,
  input  logic [7:0] new_byte,
  input  logic [7:0] old_byte,
  output logic [7:0] out_byte
);
  assign out_byte = en ? new_byte : old_byte;
endmodule

module mem_byte_responder #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_be,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  typedef struct packed {
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  localparam logic [1:0]            LAT_LAST  = 2'(MEM_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                state_q, state_d;
  req_t                  req_q, req_d;
  logic [1:0]            lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  misaligned;

  // Byte merge for partial writes: enabled bytes from the request, the rest from the memory read.
  logic [3:0][7:0] new_bytes, old_bytes, merged_bytes;
  assign new_bytes = req_q.wdata;
  assign old_bytes = mem_rdata;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    mem_byte_lane u_lane (
      .en       (req_q.be[i]),
      .new_byte (new_bytes[i]),
      .old_byte (old_bytes[i]),
      .out_byte (merged_bytes[i])
    );
  end

`ifdef MEM_BYTE_ALIGN_CHECK_EN
  // Only whole-word accesses care about alignment; partial writes name their bytes explicitly.
  assign misaligned = (req_addr[1:0] != 2'b00) && (!req_wr || (req_be == 4'b1111));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    lat_cnt_d    = lat_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wr_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d        = '{wr: req_wr, be: req_be, wdata: req_wdata};
          mem_addr_d   = req_addr & WORD_MASK;
          resp_rdata_d = '0;
          lat_cnt_d    = '0;
          if (misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_wr && (req_be == 4'b0000)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else if (req_wr && (req_be == 4'b1111)) begin
            state_d     = WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        state_d   = RD_WAIT;
        lat_cnt_d = '0;
      end
      RD_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          if (req_q.wr) begin
            state_d     = WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = merged_bytes;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      lat_cnt_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      lat_cnt_q    <= lat_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_q     <= mem_wr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_byte_responder.sv
// Bench for mem_byte_responder: two instances (latency 1 and 3) each with a word memory model,
// checked against a reference memory and a cycle-count model of each request kind.

module tb_mem_byte_responder;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } treq_t;

  typedef struct packed {
    int          rc;
    logic [31:0] rd;
    logic        er;
    int          nw;
    int          wc;
    logic [31:0] wdat;
    logic [31:0] waddr;
    logic        rdy_bad;
    logic        rdy_after;
  } tres_t;

`ifdef MEM_BYTE_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid1, req_valid3, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready1, resp_valid1, resp_err1, mem_wr1;
  logic [31:0] resp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        req_ready3, resp_valid3, resp_err3, mem_wr3;
  logic [31:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_byte_responder #(.MEM_LATENCY(1), .ADDR_WIDTH(32)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  mem_byte_responder #(.MEM_LATENCY(3), .ADDR_WIDTH(32)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Word memories: address sampled every edge, data appears MEM_LATENCY cycles later.
  logic [31:0]      mem1 [256];
  logic [31:0]      mem3 [256];
  logic [31:0]      p1;
  logic [2:0][31:0] p3;
  logic             pl_en;
  logic [7:0]       pl_addr;
  logic [31:0]      pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      mem1[pl_addr] <= pl_data;
      mem3[pl_addr] <= pl_data;
    end else begin
      if (mem_wr1) mem1[mem_addr1[9:2]] <= mem_wdata1;
      if (mem_wr3) mem3[mem_addr3[9:2]] <= mem_wdata3;
    end
    p1 <= mem1[mem_addr1[9:2]];
    p3 <= {p3[1:0], mem3[mem_addr3[9:2]]};
  end
  assign mem_rdata1 = p1;
  assign mem_rdata3 = p3[2];

  logic        sel, rdy_s, rv_s, er_s, mw_s;
  logic [31:0] rd_s, wd_s, ma_s;
  always_comb begin
    rdy_s = sel ? req_ready3  : req_ready1;
    rv_s  = sel ? resp_valid3 : resp_valid1;
    er_s  = sel ? resp_err3   : resp_err1;
    mw_s  = sel ? mem_wr3     : mem_wr1;
    rd_s  = sel ? resp_rdata3 : resp_rdata1;
    wd_s  = sel ? mem_wdata3  : mem_wdata1;
    ma_s  = sel ? mem_addr3   : mem_addr1;
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] ref_mem [2][256];

  function automatic int lat_of(input bit s);
    return s ? 3 : 1;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic bit is_mis(input treq_t r);
    return ALIGN_EN && (r.addr[1:0] != 2'b00) && (!r.wr || r.be == 4'hF);
  endfunction

  function automatic logic [31:0] mem_word(input bit s, input logic [7:0] w);
    return s ? mem3[w] : mem1[w];
  endfunction

  // Reference: what the requester should see for a request, given the current reference memory.
  function automatic tres_t model(input bit s, input treq_t r);
    tres_t e;
    bit    mis, wrt;
    logic [31:0] old;
    e   = '0;
    mis = is_mis(r);
    wrt = r.wr && !mis && (r.be != 4'h0);
    old = ref_mem[s][r.addr[9:2]];
    if (mis || (r.wr && r.be == 4'h0)) e.rc = 1;
    else if (!r.wr)                    e.rc = 2 + lat_of(s);
    else if (r.be == 4'hF)             e.rc = 2;
    else                               e.rc = 3 + lat_of(s);
    e.rd = (!r.wr && !mis) ? old : 32'h0;
    e.er = mis;
    if (wrt) begin
      e.nw    = 1;
      e.wc    = (r.be == 4'hF) ? 1 : 2 + lat_of(s);
      e.wdat  = (old & ~be_mask(r.be)) | (r.wdata & be_mask(r.be));
      e.waddr = {r.addr[31:2], 2'b00};
    end
    e.rdy_after = 1'b1;
    return e;
  endfunction

  task automatic model_commit(input bit s, input treq_t r);
    logic [7:0] w;
    w = r.addr[9:2];
    if (r.wr && !is_mis(r))
      ref_mem[s][w] = (ref_mem[s][w] & ~be_mask(r.be)) | (r.wdata & be_mask(r.be));
  endtask

  // Drives one request and records what the responder did, cycle by cycle after accept.
  task automatic run_req(input bit s, input treq_t r, input bit cont, input bit hold,
                         input treq_t nxt, output tres_t o);
    int g;
    o    = '0;
    o.rc = -1;
    if (!cont) begin
      @(negedge clk);
      sel = s; req_wr = r.wr; req_addr = r.addr; req_wdata = r.wdata; req_be = r.be;
      if (s) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    end
    #1;
    g = 0;
    while (rdy_s !== 1'b1 && g < 20) begin @(negedge clk); #1; g++; end
    if (rdy_s !== 1'b1) begin req_valid1 = 1'b0; req_valid3 = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      req_wr = nxt.wr; req_addr = nxt.addr; req_wdata = nxt.wdata; req_be = nxt.be;
    end else begin
      req_valid1 = 1'b0; req_valid3 = 1'b0;
    end
    for (int c = 1; c <= 16; c++) begin
      if (rdy_s) o.rdy_bad = 1'b1;
      if (mw_s) begin o.nw = o.nw + 1; o.wc = c; o.wdat = wd_s; o.waddr = ma_s; end
      if (rv_s) begin
        o.rc = c; o.rd = rd_s; o.er = er_s;
        @(negedge clk);
        o.rdy_after = rdy_s;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid1 = 1'b0; req_valid3 = 1'b0; pl_en = 1'b0; sel = 1'b0;
    req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({resp_valid1, resp_err1, mem_wr1, resp_rdata1, mem_addr1, mem_wdata1} !== '0) begin
      n_fail++; $display("FAIL reset_outputs1: got %h %h %h %h %h %h want all 0",
                         resp_valid1, resp_err1, mem_wr1, resp_rdata1, mem_addr1, mem_wdata1);
    end
    n_cmp++;
    if (req_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b want 1", req_ready1); end
    n_cmp++;
    if ({resp_valid3, resp_err3, mem_wr3, resp_rdata3, mem_addr3, mem_wdata3} !== '0) begin
      n_fail++; $display("FAIL reset_outputs3: got %h %h %h %h %h %h want all 0",
                         resp_valid3, resp_err3, mem_wr3, resp_rdata3, mem_addr3, mem_wdata3);
    end
    n_cmp++;
    if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL reset_ready3: got %b want 1", req_ready3); end
    reset = 1'b0;
  endtask

  task automatic preload;
    for (int w = 0; w < 256; w++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 8'(w); pl_data = $urandom;
      ref_mem[0][w] = pl_data; ref_mem[1][w] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_full_write;
    treq_t r;
    tres_t o;
    r = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF};
    run_req(0, r, 0, 0, r, o); model_commit(0, r);
    n_cmp++; if (o.rc !== 2) begin n_fail++; $display("FAIL full_wr_resp_cycle: got %0d want 2", o.rc); end
    n_cmp++; if (o.nw !== 1 || o.wc !== 1) begin n_fail++; $display("FAIL full_wr_strobe: got n=%0d c=%0d want n=1 c=1", o.nw, o.wc); end
    n_cmp++; if (o.wdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_wr_data: got %h want deadbeef", o.wdat); end
    r = '{1'b0, 32'h10, 32'h0, 4'h3};
    run_req(0, r, 0, 0, r, o);
    n_cmp++; if (o.rc !== 3 || o.rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_wr_readback: got c=%0d d=%h want c=3 d=deadbeef", o.rc, o.rd); end
  endtask

  task automatic test_partial_write;
    treq_t r;
    tres_t o;
    r = '{1'b1, 32'h20, 32'h11223344, 4'hF};
    run_req(0, r, 0, 0, r, o); model_commit(0, r);
    r = '{1'b1, 32'h20, 32'hAABBCCDD, 4'b0101};
    run_req(0, r, 0, 0, r, o); model_commit(0, r);
    n_cmp++; if (o.rc !== 4) begin n_fail++; $display("FAIL partial_resp_cycle: got %0d want 4", o.rc); end
    n_cmp++; if (o.nw !== 1 || o.wc !== 3) begin n_fail++; $display("FAIL partial_strobe: got n=%0d c=%0d want n=1 c=3", o.nw, o.wc); end
    n_cmp++; if (o.wdat !== 32'h11BB33DD) begin n_fail++; $display("FAIL partial_merge: got %h want 11bb33dd", o.wdat); end
    r = '{1'b0, 32'h20, 32'h0, 4'h0};
    run_req(0, r, 0, 0, r, o);
    n_cmp++; if (o.rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL partial_readback: got %h want 11bb33dd", o.rd); end
  endtask

  task automatic test_null_write;
    treq_t r;
    tres_t o;
    r = '{1'b1, 32'h20, $urandom, 4'h0};
    run_req(0, r, 0, 0, r, o);
    n_cmp++; if (o.rc !== 1 || o.er !== 1'b0) begin n_fail++; $display("FAIL null_resp: got c=%0d e=%b want c=1 e=0", o.rc, o.er); end
    n_cmp++; if (o.nw !== 0) begin n_fail++; $display("FAIL null_no_write: got %0d writes want 0", o.nw); end
    n_cmp++; if (mem1[8] !== 32'h11BB33DD) begin n_fail++; $display("FAIL null_mem: got %h want 11bb33dd", mem1[8]); end
  endtask

  task automatic test_back_to_back;
    treq_t a, b;
    tres_t oa, ob;
    int    extra;
    a = '{1'b1, 32'h30, $urandom, 4'hF};
    b = '{1'b0, 32'h30, 32'h0, 4'h0};
    run_req(0, a, 0, 1, b, oa); model_commit(0, a);
    run_req(0, b, 1, 0, b, ob);
    n_cmp++; if (oa.rc !== 2 || oa.rdy_bad !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got c=%0d ready_hi=%b want c=2 ready_hi=0", oa.rc, oa.rdy_bad); end
    n_cmp++; if (ob.rc !== 3 || ob.rd !== a.wdata) begin n_fail++; $display("FAIL b2b_second: got c=%0d d=%h want c=3 d=%h", ob.rc, ob.rd, a.wdata); end
    extra = 0;
    repeat (6) begin @(negedge clk); if (resp_valid1 || mem_wr1) extra++; end
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_duplicate: got %0d extra events want 0", extra); end
  endtask

  task automatic test_reset_mid;
    treq_t r;
    int    nmw, nrv;
    logic [7:0] w;
    r = '{1'b1, 32'h44, $urandom, 4'b0110};
    w = r.addr[9:2]; nmw = 0; nrv = 0;
    @(negedge clk);
    sel = 1'b0; req_wr = r.wr; req_addr = r.addr; req_wdata = r.wdata; req_be = r.be;
    req_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mw_s) nmw++;
      if (rv_s) nrv++;
      if (c == 2) reset = 1'b1;
      if (c == 3) reset = 1'b0;
      if (c == 4) begin
        n_cmp++; if (rdy_s !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", rdy_s); end
      end
      @(negedge clk);
    end
    n_cmp++; if (nmw !== 0 || nrv !== 0) begin n_fail++; $display("FAIL rstmid_activity: got wr=%0d resp=%0d want 0 0", nmw, nrv); end
    n_cmp++; if (mem1[w] !== ref_mem[0][w]) begin n_fail++; $display("FAIL rstmid_mem: got %h want %h", mem1[w], ref_mem[0][w]); end
  endtask

  task automatic test_align;
    treq_t r;
    tres_t o;
    r = '{1'b0, 32'h22, 32'h0, 4'hF};
    for (int s = 0; s < 2; s++) begin
      run_req(s[0], r, 0, 0, r, o);
      n_cmp++;
      if (o.rc !== (ALIGN_EN ? 1 : 2 + lat_of(s[0]))) begin
        n_fail++; $display("FAIL align_cycle%0d: got %0d want %0d", s, o.rc, ALIGN_EN ? 1 : 2 + lat_of(s[0]));
      end
      n_cmp++;
      if (o.er !== ALIGN_EN || o.rd !== (ALIGN_EN ? 32'h0 : ref_mem[s][8]) || o.nw !== 0) begin
        n_fail++; $display("FAIL align_resp%0d: got e=%b d=%h w=%0d want e=%b d=%h w=0", s, o.er, o.rd, o.nw,
                           ALIGN_EN, ALIGN_EN ? 32'h0 : ref_mem[s][8]);
      end
    end
  endtask

  task automatic test_random(input bit s, input int n);
    treq_t r;
    tres_t o, e;
    logic [7:0] w;
    int k;
    for (int i = 0; i < n; i++) begin
      r.wr    = 1'($urandom_range(0, 1));
      r.addr  = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      r.wdata = $urandom;
      k = $urandom_range(0, 3);
      r.be = (k == 0) ? 4'hF : (k == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      w = r.addr[9:2];
      e = model(s, r);
      run_req(s, r, 0, 0, r, o);
      model_commit(s, r);
      n_cmp++; if (o.rc !== e.rc) begin n_fail++; $display("FAIL rnd_timing[%0d]: got %0d want %0d", i, o.rc, e.rc); end
      n_cmp++; if ({o.rd, o.er} !== {e.rd, e.er}) begin n_fail++; $display("FAIL rnd_resp[%0d]: got %h/%b want %h/%b", i, o.rd, o.er, e.rd, e.er); end
      n_cmp++;
      if ({o.nw, o.wc, o.wdat, o.waddr} !== {e.nw, e.wc, e.wdat, e.waddr}) begin
        n_fail++; $display("FAIL rnd_write[%0d]: got n=%0d c=%0d d=%h a=%h want n=%0d c=%0d d=%h a=%h",
                           i, o.nw, o.wc, o.wdat, o.waddr, e.nw, e.wc, e.wdat, e.waddr);
      end
      n_cmp++; if ({o.rdy_bad, o.rdy_after} !== 2'b01) begin n_fail++; $display("FAIL rnd_ready[%0d]: got busy_hi=%b after=%b want 0 1", i, o.rdy_bad, o.rdy_after); end
      n_cmp++; if (mem_word(s, w) !== ref_mem[s][w]) begin n_fail++; $display("FAIL rnd_mem[%0d]: got %h want %h", i, mem_word(s, w), ref_mem[s][w]); end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_full_write();
    test_partial_write();
    test_null_write();
    test_back_to_back();
    test_reset_mid();
    test_align();
    test_random(1'b0, 40);
    test_random(1'b1, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_byte_responder.md
Name: mem_byte_responder

Overview:
- Memory-side responder between the multicycle core's memory port and the single-port `Memoria` word memory.
- Accepts one request at a time over a valid/ready handshake: word read, full-word write, or byte-enabled partial write.
- Partial writes run as an internal read-modify-write sequence, so the core's `mem_wr_byte_enable` becomes usable without changing `Memoria`.
- Returns a one-cycle response pulse carrying read data and an error flag.

Parameters:
- MEM_LATENCY, 1: cycles from the edge at which `Memoria` samples an address to valid `mem_rdata`; legal range 1..4.
- ADDR_WIDTH, 32: width of request and memory addresses.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present; requester holds it and all req_* fields until accepted
- req_ready  out  1  responder idle and able to accept
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  write data, byte i in bits 8i+7:8i
- req_be  in  4  byte enables; be[i] enables bits 8i+7:8i; ignored on reads
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  read data; valid while resp_valid is high
- resp_err  out  1  access rejected; valid while resp_valid is high
- mem_addr  out  ADDR_WIDTH  word-aligned address to `Memoria`
- mem_wr  out  1  `Memoria` write strobe
- mem_wdata  out  32  `Memoria` write data
- mem_rdata  in  32  `Memoria` read data

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE. `resp_valid`, `resp_err`, `mem_wr` = 0; `resp_rdata`, `mem_addr`, `mem_wdata` = 0; latency counter = 0.
- Output timing: all outputs are registered except `req_ready`, which is combinational and equals (state == IDLE).
- Accept: `req_valid & req_ready` at edge E0. The request is captured into internal registers; `req_*` inputs are ignored until IDLE is re-entered. There is no queueing.
- Address: the word address is `req_addr` with bits [1:0] forced to 0.
- States: IDLE, RD, RD_WAIT, WR, RESP.
- Cycle Cn is the cycle following edge En. Timings below are for MEM_LATENCY = 1; each extra latency cycle adds one cycle to every access that reads memory.
- Read: C1 RD, `mem_addr` driven, `mem_wr` = 0. RD_WAIT counts MEM_LATENCY cycles. At E2 `mem_rdata` is captured into `resp_rdata`. C3 RESP with `resp_valid` = 1.
- Full write (`req_be` = 4'b1111): C1 WR with `mem_wr` = 1, `mem_addr`, `mem_wdata` = `req_wdata`. C2 RESP. `resp_rdata` = 0.
- Partial write (`req_be` not 0000 and not 1111): C1 RD and RD_WAIT as for a read. At E2 merge: byte i = `req_wdata` byte if be[i], else the read byte. C3 WR with merged data, `mem_wr` = 1. C4 RESP. Disabled bytes must remain bit-identical in memory.
- Null write (`req_be` = 4'b0000): no memory access. C1 RESP, `resp_err` = 0.
- `mem_wr` is high for exactly one cycle per write and only in WR.
- RESP: `resp_valid` is high for exactly one cycle, with no backpressure. The next state is IDLE, so `req_ready` returns in the following cycle. Back-to-back accepted requests are therefore at least (own latency + 1) cycles apart.
- Reset mid-operation: abandons the access. No write is issued after the reset edge and no response is generated. The only exception is a WR cycle already in progress in the same cycle as reset, whose write completes.
- `req_valid` deasserting while not accepted is legal; nothing happens.

Optional Feature:
- Macro: MEM_BYTE_ALIGN_CHECK_EN.
- Defined: if `req_addr[1:0]` != 00 and (`req_wr` = 0 or `req_be` = 4'b1111), the request is accepted but no memory access occurs. C1 RESP with `resp_err` = 1 and `resp_rdata` = 0. The core maps this to its exception cause.
- Undefined: `req_addr[1:0]` is silently ignored, `resp_err` is tied to 0, and all requests proceed normally.

Test Plan:
- Reset, then full write addr 0x10, data 0xDEADBEEF, be 1111 -> `mem_wr` is high only in C1, `resp_valid` in C2. A subsequent read of 0x10 returns 0xDEADBEEF with `resp_valid` 3 cycles after accept.
- Memory at 0x20 = 0x11223344; write data 0xAABBCCDD, be 0101 -> read in C1, single write in C3 of 0x11BB33DD, resp in C4. Read-back gives 0x11BB33DD.
- Null write be 0000 to 0x20 -> `mem_wr` never asserts, `resp_valid` in C1, memory unchanged.
- `req_valid` held high continuously with two queued requests -> second is accepted only after RESP and IDLE. `req_ready` is low throughout the first access; no request is lost or duplicated.
- Reset asserted in RD_WAIT of a partial write -> no `mem_wr`, no `resp_valid`, memory word unchanged, IDLE with `req_ready` = 1 the cycle after reset deasserts.
- With MEM_BYTE_ALIGN_CHECK_EN: read 0x22 -> `resp_err` = 1 in C1, no memory access. Without it: read 0x22 returns the word at 0x20 with `resp_err` = 0. Repeat the read with MEM_LATENCY = 3 -> `resp_valid` 5 cycles after accept.
